tmr32_alarm_sched: RTL and testbench

Alarm scheduler that shares one TIMER32 instance among `NUM_CH` requesters. Each requester arms a one-shot relative delay. The block keeps per-channel absolute deadlines and programs the timer compare register with the earliest one. It takes the overflow flag, clears it, and signals expiry to the owning channel or channels. It sits between the timer register fields (TMR, TMRCMP, TMROV, TMROVCLR, TMREN) and on-chip hardware clients that need timeouts.

---
 rtl/tmr32_alarm_sched_if.sv | 27 ++
 rtl/tmr32_alarm_sched.sv | 159 +++++++++++++++
 tb/tb_tmr32_alarm_sched.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tmr32_alarm_sched_if.sv
// Requester and timer-register bundle shared by the alarm scheduler
// and its clients; the slave side is the scheduler itself.
interface tmr32_alarm_sched_if #(
    parameter int NUM_CH = 4
);
    logic [NUM_CH-1:0]    arm_valid;
    logic [NUM_CH*32-1:0] arm_delay;
    logic [NUM_CH-1:0]    arm_ready;
    logic [NUM_CH-1:0]    cancel;
    logic [NUM_CH-1:0]    expired;
    logic [NUM_CH-1:0]    armed;
    logic [31:0]          TMR;
    logic                 TMROV;
    logic [31:0]          TMRCMP;
    logic                 TMROVCLR;
    logic                 TMREN;

    modport master (
        output arm_valid, arm_delay, cancel, TMR, TMROV,
        input  arm_ready, expired, armed, TMRCMP, TMROVCLR, TMREN
    );

    modport slave (
        input  arm_valid, arm_delay, cancel, TMR, TMROV,
        output arm_ready, expired, armed, TMRCMP, TMROVCLR, TMREN
    );
endinterface

// File: rtl/tmr32_alarm_sched.sv
// Multiplexes per-channel one-shot deadlines onto a single TIMER32
// compare register, earliest deadline first.
module tmr32_alarm_sched #(
    parameter int NUM_CH = 4
) (
    input  logic               PCLK,
    input  logic               PRESETn,
    tmr32_alarm_sched_if.slave bus
);
    localparam int          KW      = $clog2(NUM_CH);
    localparam logic [31:0] MAX_DLY = 32'h7FFF_FFFF;

    typedef enum logic [2:0] {
        S_IDLE, S_SCAN, S_LOAD, S_WAIT, S_EXPIRE
    } state_t;

    state_t state, state_nxt;

    logic [31:0]        deadline [NUM_CH];
    logic signed [31:0] diff [NUM_CH];
    logic [NUM_CH-1:0]  armed_q, armed_nxt;
    logic [NUM_CH-1:0]  grant, accept, due, expired_q;
    logic [KW-1:0]      scan_k;
    logic signed [31:0] best_diff, k_diff;
    logic [31:0]        best_dl, cmp_q;
    logic               best_valid, any_due, any_due_nxt;
    logic               k_armed, k_due, k_better, scan_last;
    logic               rescan, ovclr_q, en_q;

    function automatic logic [31:0] sat_delay(input logic [31:0] d);
        return d[31] ? MAX_DLY : d;
    endfunction

    // Wrap-safe signed distance to each deadline
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            diff[i] = $signed(deadline[i] - bus.TMR);
            due[i]  = armed_q[i] && (diff[i] <= 0);
        end
    end

    always_comb begin
        grant = '0;
        if (state == S_IDLE || state == S_WAIT) begin
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                if (bus.arm_valid[i]) begin
                    grant    = '0;
                    grant[i] = 1'b1;
                end
            end
        end
    end

    assign accept = bus.arm_valid & grant;
    assign rescan = (|accept) | (|(bus.cancel & armed_q));

    assign k_diff      = diff[scan_k];
    assign k_armed     = armed_q[scan_k];
    assign k_due       = k_armed && (k_diff <= 0);
    assign k_better    = k_armed && (!best_valid || k_diff < best_diff);
    assign scan_last   = (scan_k == KW'(NUM_CH - 1));
    assign any_due_nxt = any_due | k_due;

    // Cancel beats expiry; an arm in the same cycle beats cancel
    always_comb begin
        armed_nxt = armed_q & ~bus.cancel;
        if (state == S_EXPIRE)
            armed_nxt = armed_nxt & ~due;
        armed_nxt = armed_nxt | accept;
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:
                if (|accept)
                    state_nxt = S_SCAN;
            S_SCAN:
                if (scan_last) begin
                    if (any_due_nxt)
                        state_nxt = S_EXPIRE;
                    else if (|armed_nxt)
                        state_nxt = S_LOAD;
                    else
                        state_nxt = S_IDLE;
                end
            S_LOAD:
                state_nxt = S_WAIT;
            S_WAIT:
                if (rescan)
                    state_nxt = S_SCAN;
                else if (bus.TMROV)
                    state_nxt = S_EXPIRE;
            S_EXPIRE:
                state_nxt = S_SCAN;
            default:
                state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            armed_q    <= '0;
            expired_q  <= '0;
            ovclr_q    <= 1'b0;
            en_q       <= 1'b0;
            cmp_q      <= '0;
            scan_k     <= '0;
            any_due    <= 1'b0;
            best_valid <= 1'b0;
            best_diff  <= '0;
            best_dl    <= '0;
            for (int i = 0; i < NUM_CH; i++)
                deadline[i] <= '0;
        end else begin
            en_q      <= 1'b1;
            armed_q   <= armed_nxt;
            ovclr_q   <= (state == S_EXPIRE);
            expired_q <= (state == S_EXPIRE) ? (due & ~bus.cancel) : '0;
            for (int i = 0; i < NUM_CH; i++) begin
                if (accept[i])
                    deadline[i] <= bus.TMR
                        + sat_delay(bus.arm_delay[32*i +: 32]);
            end
            if (state == S_LOAD)
                cmp_q <= best_dl;
            // best_dl survives into LOAD; only the scan flags restart
            if (state == S_SCAN) begin
                scan_k  <= scan_last ? '0 : scan_k + KW'(1);
                any_due <= any_due_nxt;
                if (k_better) begin
                    best_valid <= 1'b1;
                    best_diff  <= k_diff;
                    best_dl    <= deadline[scan_k];
                end
            end else begin
                scan_k     <= '0;
                any_due    <= 1'b0;
                best_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        bus.arm_ready = grant;
        bus.expired   = expired_q;
        bus.armed     = armed_q;
        bus.TMRCMP    = cmp_q;
        bus.TMROVCLR  = ovclr_q;
        bus.TMREN     = en_q;
    end
endmodule

// File: tb/tb_tmr32_alarm_sched.sv
// Directed bench for tmr32_alarm_sched with a behavioural TIMER32
// (free-running count, sticky compare flag cleared by TMROVCLR).
module tb_tmr32_alarm_sched;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] tmr, tmr_val;
    logic        tmr_set, ov;
    int          errs = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    tmr32_alarm_sched_if #(.NUM_CH(N)) bus ();

    tmr32_alarm_sched #(.NUM_CH(N)) dut (
        .PCLK   (clk),
        .PRESETn(rst_n),
        .bus    (bus)
    );

    always @(posedge clk) begin
        if (tmr_set)        tmr <= tmr_val;
        else if (bus.TMREN) tmr <= tmr + 32'd1;
        if (tmr_set || bus.TMROVCLR)                ov <= 1'b0;
        else if (bus.TMREN && tmr == bus.TMRCMP)    ov <= 1'b1;
    end

    assign bus.TMR   = tmr;
    assign bus.TMROV = ov;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_tmr(input logic [31:0] v);
        tmr_set = 1'b1;
        tmr_val = v;
        step();
        tmr_set = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.arm_valid = '0;
        bus.cancel = '0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic grant(input int ch, output logic [31:0] at, output int cyc);
        cyc = 0;
        bus.arm_valid[ch] = 1'b1;
        #1;
        while (!bus.arm_ready[ch] && cyc < 40) begin
            step();
            #1;
            cyc++;
        end
        at = tmr;
        step();
        bus.arm_valid[ch] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.arm_valid = '0;
        bus.arm_delay = '0;
        bus.cancel = '0;
        set_tmr(32'h0);
        step();
        checks++; if (bus.TMREN !== 1'b0) begin errs++; $display("FAIL reset_tmren: got %b want 0", bus.TMREN); end
        checks++; if (bus.TMRCMP !== 32'h0) begin errs++; $display("FAIL reset_tmrcmp: got %h want 0", bus.TMRCMP); end
        checks++; if (bus.TMROVCLR !== 1'b0) begin errs++; $display("FAIL reset_ovclr: got %b want 0", bus.TMROVCLR); end
        checks++; if (bus.expired !== 4'h0) begin errs++; $display("FAIL reset_expired: got %b want 0000", bus.expired); end
        checks++; if (bus.armed !== 4'h0) begin errs++; $display("FAIL reset_armed: got %b want 0000", bus.armed); end
        rst_n = 1'b1;
        step();
        checks++; if (bus.TMREN !== 1'b1) begin errs++; $display("FAIL release_tmren: got %b want 1", bus.TMREN); end
    endtask

    task automatic test_single();
        logic [31:0] at, ptmr;
        int cyc, np, nc;
        do_reset();
        set_tmr(32'h1000);
        bus.arm_delay[31:0] = 32'd100;
        grant(0, at, cyc);
        checks++; if (cyc !== 0) begin errs++; $display("FAIL single_grant_wait: got %0d want 0", cyc); end
        repeat (5) step();
        checks++; if (bus.TMRCMP !== 32'h1064) begin errs++; $display("FAIL single_cmp: got %h want 00001064", bus.TMRCMP); end
        np = 0; nc = 0; ptmr = '0;
        for (int i = 0; i < 130; i++) begin
            step();
            if (bus.expired[0]) begin np++; ptmr = tmr; end
            if (bus.TMROVCLR) nc++;
        end
        checks++; if (np !== 1) begin errs++; $display("FAIL single_pulses: got %0d want 1", np); end
        checks++; if (nc !== 1) begin errs++; $display("FAIL single_ovclr: got %0d want 1", nc); end
        checks++; if (ptmr < 32'h1064 || ptmr > 32'h1068) begin errs++; $display("FAIL single_when: got tmr %h want 1064..1068", ptmr); end
        checks++; if (bus.armed !== 4'h0) begin errs++; $display("FAIL single_armed: got %b want 0000", bus.armed); end
        bus.arm_valid[0] = 1'b1;
        #1;
        checks++; if (bus.arm_ready !== 4'b0001) begin errs++; $display("FAIL single_idle: got ready %b want 0001", bus.arm_ready); end
        bus.arm_valid = '0;
    endtask

    task automatic test_order();
        logic [31:0] t0, t1, cmp2;
        logic [3:0] p1, p2;
        int c0, c1, np, pi;
        do_reset();
        set_tmr(32'h100);
        bus.arm_delay[31:0] = 32'd300;
        bus.arm_delay[63:32] = 32'd50;
        bus.arm_valid = 4'b0011;
        #1;
        checks++; if (bus.arm_ready !== 4'b0001) begin errs++; $display("FAIL order_onehot: got %b want 0001", bus.arm_ready); end
        grant(0, t0, c0);
        repeat (5) step();
        checks++; if (bus.TMRCMP !== 32'h22C) begin errs++; $display("FAIL order_cmp0: got %h want 0000022c", bus.TMRCMP); end
        grant(1, t1, c1);
        checks++; if (t1 !== 32'h106) begin errs++; $display("FAIL order_t1: got %h want 00000106", t1); end
        repeat (5) step();
        checks++; if (bus.TMRCMP !== 32'h138) begin errs++; $display("FAIL order_cmp1: got %h want 00000138", bus.TMRCMP); end
        np = 0; pi = -1; p1 = '0; p2 = '0; cmp2 = '0;
        for (int i = 0; i < 400; i++) begin
            step();
            if (pi >= 0 && i == pi + 6) cmp2 = bus.TMRCMP;
            if (bus.expired != 4'h0) begin
                np++;
                if (np == 1) begin p1 = bus.expired; pi = i; end
                else if (np == 2) p2 = bus.expired;
            end
        end
        checks++; if (p1 !== 4'b0010) begin errs++; $display("FAIL order_first: got %b want 0010", p1); end
        checks++; if (cmp2 !== 32'h22C) begin errs++; $display("FAIL order_reload: got %h want 0000022c", cmp2); end
        checks++; if (p2 !== 4'b0001) begin errs++; $display("FAIL order_second: got %b want 0001", p2); end
        checks++; if (np !== 2) begin errs++; $display("FAIL order_count: got %0d want 2", np); end
    endtask

    task automatic test_wrap();
        logic [31:0] at, ptmr;
        int cyc, np, early;
        do_reset();
        set_tmr(32'hFFFF_FFF0);
        bus.arm_delay[31:0] = 32'h20;
        grant(0, at, cyc);
        repeat (5) step();
        checks++; if (bus.TMRCMP !== 32'h10) begin errs++; $display("FAIL wrap_cmp: got %h want 00000010", bus.TMRCMP); end
        np = 0; early = 0; ptmr = '0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (bus.expired[0]) begin
                np++;
                ptmr = tmr;
                if (tmr > 32'h8000_0000) early++;
            end
        end
        checks++; if (np !== 1) begin errs++; $display("FAIL wrap_pulses: got %0d want 1", np); end
        checks++; if (early !== 0) begin errs++; $display("FAIL wrap_early: got %0d want 0", early); end
        checks++; if (ptmr < 32'h10 || ptmr > 32'h14) begin errs++; $display("FAIL wrap_when: got tmr %h want 10..14", ptmr); end
    endtask

    task automatic test_cancel();
        logic [31:0] at;
        int cyc, np;
        do_reset();
        set_tmr(32'h2000);
        bus.arm_delay[95:64] = 32'd1000;
        grant(2, at, cyc);
        repeat (6) step();
        checks++; if (bus.armed !== 4'b0100) begin errs++; $display("FAIL cancel_armed: got %b want 0100", bus.armed); end
        bus.cancel[2] = 1'b1;
        step();
        bus.cancel = '0;
        checks++; if (bus.armed !== 4'h0) begin errs++; $display("FAIL cancel_cleared: got %b want 0000", bus.armed); end
        np = 0;
        for (int i = 0; i < 1100; i++) begin
            step();
            if (bus.expired[2]) np++;
        end
        checks++; if (np !== 0) begin errs++; $display("FAIL cancel_pulses: got %0d want 0", np); end
        bus.arm_valid[3] = 1'b1;
        #1;
        checks++; if (bus.arm_ready !== 4'b1000) begin errs++; $display("FAIL cancel_idle: got ready %b want 1000", bus.arm_ready); end
        bus.arm_valid = '0;
        set_tmr(32'h5000);
        bus.arm_delay[63:32] = 32'd0;
        grant(1, at, cyc);
        repeat (4) step();
        bus.cancel[1] = 1'b1;
        step();
        bus.cancel = '0;
        np = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.expired[1]) np++;
        end
        checks++; if (np !== 0) begin errs++; $display("FAIL cancel_expire_pulse: got %0d want 0", np); end
        checks++; if (bus.armed !== 4'h0) begin errs++; $display("FAIL cancel_expire_armed: got %b want 0000", bus.armed); end
    endtask

    task automatic test_late_simul();
        logic [31:0] t0, t2;
        logic [3:0] p1;
        int cyc, hit, ovseen, np;
        do_reset();
        set_tmr(32'h6000);
        bus.arm_delay[127:96] = 32'd0;
        grant(3, t0, cyc);
        hit = -1; ovseen = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (ov) ovseen = 1;
            if (bus.expired[3] && hit < 0) hit = i;
        end
        checks++; if (hit !== N + 1) begin errs++; $display("FAIL late_latency: got %0d want %0d", hit, N + 1); end
        checks++; if (ovseen !== 0) begin errs++; $display("FAIL late_tmrov: got %0d want 0", ovseen); end
        set_tmr(32'h7000);
        bus.arm_delay[31:0] = 32'd206;
        bus.arm_delay[95:64] = 32'd200;
        bus.arm_valid = 4'b0101;
        #1;
        checks++; if (bus.arm_ready !== 4'b0001) begin errs++; $display("FAIL simul_first: got %b want 0001", bus.arm_ready); end
        grant(0, t0, cyc);
        grant(2, t2, cyc);
        checks++; if (t2 !== 32'h7006) begin errs++; $display("FAIL simul_second_tmr: got %h want 00007006", t2); end
        np = 0; p1 = '0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (bus.expired != 4'h0) begin np++; if (np == 1) p1 = bus.expired; end
        end
        checks++; if (p1 !== 4'b0101) begin errs++; $display("FAIL equal_pulse: got %b want 0101", p1); end
        checks++; if (np !== 1) begin errs++; $display("FAIL equal_count: got %0d want 1", np); end
    endtask

    task automatic test_reset_wait();
        logic [31:0] at;
        int cyc, np;
        do_reset();
        set_tmr(32'h9000);
        bus.arm_delay[31:0] = 32'd500;
        grant(0, at, cyc);
        repeat (6) step();
        checks++; if (bus.armed !== 4'b0001) begin errs++; $display("FAIL rstw_armed: got %b want 0001", bus.armed); end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++; if (bus.TMREN !== 1'b0) begin errs++; $display("FAIL rstw_tmren: got %b want 0", bus.TMREN); end
        checks++; if (bus.TMRCMP !== 32'h0) begin errs++; $display("FAIL rstw_cmp: got %h want 0", bus.TMRCMP); end
        checks++; if (bus.armed !== 4'h0) begin errs++; $display("FAIL rstw_armed0: got %b want 0000", bus.armed); end
        checks++; if (bus.TMROVCLR !== 1'b0) begin errs++; $display("FAIL rstw_ovclr: got %b want 0", bus.TMROVCLR); end
        step();
        checks++; if (bus.TMREN !== 1'b1) begin errs++; $display("FAIL rstw_tmren1: got %b want 1", bus.TMREN); end
        np = 0;
        for (int i = 0; i < 600; i++) begin
            step();
            if (bus.expired != 4'h0) np++;
        end
        checks++; if (np !== 0) begin errs++; $display("FAIL rstw_pulses: got %0d want 0", np); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_order();
        test_wrap();
        test_cancel();
        test_late_simul();
        test_reset_wait();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
